matrix_key_scan: RTL and testbench
==================================

Name: matrix_key_scan

Overview:
- Upstream stage of the 4x4 keypad path for the password lock.
- Drives the keypad rows one at a time and samples the columns.
- Assembles a 16-bit frame and debounces it across whole frames.
- Presents a stable level-per-key vector `key[15:0]` (1 = pressed) to the edge-capture stage.

Parameters:
- SCAN_DIV, 50000: clk cycles each row is driven (1 ms at 50 MHz). Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical frames required before `key` updates. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- col_n  input  4  keypad columns, active-low (pulled up); asynchronous to clk
- row_n  output  4  keypad row drive, active-low, one-hot-low
- key  output  16  debounced key state; bit = row*4+col; 1 = pressed
- key_update  output  1  one-cycle pulse on the cycle `key` changes value

Behaviour:
- Reset (async, active-high), all outputs go to these values:
  - row_n=4'b1110 (row 0 driven)
  - key=16'h0000, key_update=0
  - row index=0, divider=0, candidate frame=0, stable count=0
- Synchronizer:
  - col_n passes through a 2-flop synchronizer, reset to 4'b1111.
  - Sampling uses only the synchronized value.
- Row sequencing:
  - The divider counts 0..SCAN_DIV-1.
  - On divider==SCAN_DIV-1 (the "sample cycle"):
    - the divider wraps to 0;
    - the row index advances 0→1→2→3→0;
    - row_n becomes ~(1<<next_row) on the same edge.
  - Frame period = 4*SCAN_DIV cycles.
- Column sampling:
  - On the sample cycle of row r, frame bits [r*4+3:r*4] <= ~col_sync.
  - Sampling the last cycle of the slot allows SCAN_DIV-3 cycles of settle after the row switch plus synchronizer delay.
- Frame completion is the sample cycle of row 3. The new frame is the stored rows 0-2 merged with the row-3 sample taken combinationally on that cycle.
- Debounce, evaluated on the frame-completion edge:
  - new frame != candidate: candidate <= new frame; count <= 1.
  - new frame == candidate: count <= min(count+1, DEBOUNCE_SCANS). The count saturates and never wraps.
  - If the updated count >= DEBOUNCE_SCANS and candidate != key: key <= candidate; key_update=1 for exactly that cycle.
  - DEBOUNCE_SCANS=1: key follows every frame.
- Latency: a press that is clean from the start of frame N updates `key` at the completion edge of frame N+DEBOUNCE_SCANS-1. Release behaves symmetrically.
- Boundary conditions:
  - A bounce inside any frame restarts the count at 1; `key` holds its previous value.
  - Multiple keys pressed are all reported; there is no masking unless the optional feature is enabled.
  - A key pressed mid-frame lands only in the row slots that sample after it. That frame differs from the next one, so the count restarts.
  - Reset asserted mid-frame discards the partial frame and the candidate; `key` clears to 0 with no key_update pulse.
  - Divider and row index never exceed their ranges.

Optional Feature:
- Macro: MATRIX_KEY_GHOST_REJECT_EN
- Defined:
  - A completed frame with more than 2 bits set is invalid; ghosting is possible on an undiode'd matrix.
  - On an invalid frame, candidate <= invalid frame and count <= 0, so no update is possible from that frame.
  - `key` holds its last valid value.
- Undefined: popcount logic is not generated; all frames are valid.

Decomposition:
- Shared package `matrix_key_pkg`:
  - KEY_ROWS=4, KEY_COLS=4, KEY_W=16;
  - the key index function row*KEY_COLS+col.
  - The edge-capture and password-lock stages use the same package.
- One sub-module: `matrix_key_debounce`.
  - Holds the candidate register, saturating count, key register, key_update, and the optional ghost check.
  - Input: frame[15:0] plus frame_valid pulse.
  - The scanner top holds the divider, row FSM, synchronizer and frame assembly.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, keypad model shorts row r to col c when pressed, col_n=~(pressed & ~row_n)):
- Reset:
  - Stimulus: assert rst mid-scan with key 9 held.
  - Required: row_n=4'b1110, key=0, key_update=0 immediately; after release, row_n rotates 1110→1101→1011→0111 every 4 cycles.
- Single press:
  - Stimulus: press row 2 col 1 from frame start.
  - Required: key=16'h0200 with one key_update pulse at the end of the 3rd frame (cycle 48 after frame start); no earlier change.
- Bounce:
  - Stimulus: toggle key 9 every 20 cycles for 200 cycles, then hold.
  - Required: key stays 0 during toggling; becomes 16'h0200 three full frames after the toggling stops.
- Release and multi-key:
  - Stimulus: hold keys 0 and 15, then release both.
  - Required: key=16'h8001, then 16'h0000 three frames after release; exactly 2 key_update pulses in total.
- Ghost, with MATRIX_KEY_GHOST_REJECT_EN defined:
  - Stimulus: hold keys 0, 1, 4.
  - Required: key keeps its prior value and no key_update occurs.
  - Same stimulus with the macro undefined: key=16'h0013.

Source files
------------

// File: rtl/matrix_key_scan_pkg.sv
// matrix_key_pkg: keypad geometry, row states and key index shared by the keypad path
package matrix_key_pkg;
  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_W = KEY_ROWS * KEY_COLS;
  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_e;
  function automatic int key_idx(int row, int col);
    return row * KEY_COLS + col;
  endfunction
endpackage

// File: rtl/matrix_key_scan_if.sv
// matrix_key_scan_if: keypad pins and debounced key bus; master is the scanner side
interface matrix_key_scan_if;
  import matrix_key_pkg::*;
  logic [KEY_COLS-1:0] col_n;
  logic [KEY_ROWS-1:0] row_n;
  logic [KEY_W-1:0] key;
  logic key_update;
  modport master(input col_n, output row_n, key, key_update);
  modport slave(output col_n, input row_n, key, key_update);
endinterface

// File: rtl/matrix_key_debounce.sv
// matrix_key_debounce: whole-frame debounce; MATRIX_KEY_GHOST_REJECT_EN drops frames with >2 keys
module matrix_key_debounce
  import matrix_key_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] frame,
  input  logic             frame_valid,
  output logic [KEY_W-1:0] key,
  output logic             key_update
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  logic [KEY_W-1:0] cand;
  logic [CW-1:0] cnt, cnt_nx;
  logic valid, upd;
`ifdef MATRIX_KEY_GHOST_REJECT_EN
  assign valid = $countones(frame) <= 2;
`else
  assign valid = 1'b1;
`endif
  // an invalid frame zeroes the count so it can never reach the update threshold
  always_comb begin
    cnt_nx = !valid ? '0 : frame != cand ? CW'(1) : cnt == CW'(DEBOUNCE_SCANS) ? cnt : cnt + 1'b1;
    upd = frame_valid && cnt_nx >= CW'(DEBOUNCE_SCANS) && frame != key;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cand <= '0;
      cnt <= '0;
      key <= '0;
      key_update <= 1'b0;
    end else begin
      key_update <= upd;
      if (upd) key <= frame;
      if (frame_valid) begin
        cand <= frame;
        cnt <= cnt_nx;
      end
    end
endmodule

// File: rtl/matrix_key_scan.sv
// matrix_key_scan: 4x4 keypad row scanner and frame assembler; MATRIX_KEY_GHOST_REJECT_EN enables ghost rejection
module matrix_key_scan
  import matrix_key_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic clk,
  input logic rst,
  matrix_key_scan_if.master bus
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [DW-1:0] div;
  row_e row, row_nx;
  logic [KEY_COLS-1:0] col_m, col_s;
  logic [KEY_W-KEY_COLS-1:0] part;
  logic sample, frame_valid;
  logic [KEY_W-1:0] frame;
  assign sample = div == DW'(SCAN_DIV - 1);
  assign row_nx = row_e'(row + 2'd1);
  assign frame_valid = sample && row == ROW3;
  // the last row is merged straight from the synchronizer on the completion cycle
  assign frame = {~col_s, part};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_m <= '1;
      col_s <= '1;
      div <= '0;
      row <= ROW0;
      bus.row_n <= 4'b1110;
      part <= '0;
    end else begin
      col_m <= bus.col_n;
      col_s <= col_m;
      div <= sample ? '0 : div + 1'b1;
      if (sample) begin
        row <= row_nx;
        bus.row_n <= ~(KEY_ROWS'(1) << row_nx);
        if (row != ROW3) part[row*KEY_COLS +: KEY_COLS] <= ~col_s;
      end
    end
  matrix_key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk(clk),
    .rst(rst),
    .frame(frame),
    .frame_valid(frame_valid),
    .key(bus.key),
    .key_update(bus.key_update)
  );
endmodule

// File: tb/tb_matrix_key_scan.sv
// tb_matrix_key_scan: directed bench with a shorting keypad model, SCAN_DIV=4, DEBOUNCE_SCANS=3
module tb_matrix_key_scan;
  import matrix_key_pkg::*;
  logic clk, rst;
  logic [15:0] pressed;
  logic [3:0] hit;
  int checks = 0, failures = 0, upd = 0, base;
  matrix_key_scan_if bus ();
  matrix_key_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_comb begin
    hit = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        hit[c] = hit[c] | (pressed[key_idx(r, c)] & ~bus.row_n[r]);
  end
  assign bus.col_n = ~hit;
  always @(negedge clk) if (bus.key_update === 1'b1) upd++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [15:0] p);
    pressed = p;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    start(16'h0000);
    checks++; if (bus.row_n !== 4'b1110) begin failures++; $display("FAIL rst_row_n got=%b exp=1110", bus.row_n); end
    checks++; if (bus.key !== 16'h0000) begin failures++; $display("FAIL rst_key got=%h exp=0000", bus.key); end
    checks++; if (bus.key_update !== 1'b0) begin failures++; $display("FAIL rst_key_update got=%b exp=0", bus.key_update); end
    pressed = 16'h0200;
    tick(60);
    checks++; if (bus.key !== 16'h0200) begin failures++; $display("FAIL pre_rst_key got=%h exp=0200", bus.key); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.row_n !== 4'b1110) begin failures++; $display("FAIL async_row_n got=%b exp=1110", bus.row_n); end
    checks++; if (bus.key !== 16'h0000) begin failures++; $display("FAIL async_key got=%h exp=0000", bus.key); end
    checks++; if (bus.key_update !== 1'b0) begin failures++; $display("FAIL async_key_update got=%b exp=0", bus.key_update); end
    tick(2);
    rst = 1'b0;
    tick(3);
    checks++; if (bus.row_n !== 4'b1110) begin failures++; $display("FAIL rot0 got=%b exp=1110", bus.row_n); end
    tick(1);
    checks++; if (bus.row_n !== 4'b1101) begin failures++; $display("FAIL rot1 got=%b exp=1101", bus.row_n); end
    tick(4);
    checks++; if (bus.row_n !== 4'b1011) begin failures++; $display("FAIL rot2 got=%b exp=1011", bus.row_n); end
    tick(4);
    checks++; if (bus.row_n !== 4'b0111) begin failures++; $display("FAIL rot3 got=%b exp=0111", bus.row_n); end
    tick(4);
    checks++; if (bus.row_n !== 4'b1110) begin failures++; $display("FAIL rot_wrap got=%b exp=1110", bus.row_n); end
    tick(31);
    checks++; if (bus.key !== 16'h0000) begin failures++; $display("FAIL post_rst_early got=%h exp=0000", bus.key); end
    tick(1);
    checks++; if (bus.key !== 16'h0200) begin failures++; $display("FAIL post_rst_key got=%h exp=0200", bus.key); end
  endtask

  task automatic test_single_press;
    start(16'h0200);
    base = upd;
    tick(47);
    checks++; if (bus.key !== 16'h0000) begin failures++; $display("FAIL press_early got=%h exp=0000", bus.key); end
    checks++; if (upd - base !== 0) begin failures++; $display("FAIL press_early_pulses got=%0d exp=0", upd - base); end
    tick(1);
    checks++; if (bus.key !== 16'h0200) begin failures++; $display("FAIL press_key got=%h exp=0200", bus.key); end
    checks++; if (bus.key_update !== 1'b1) begin failures++; $display("FAIL press_pulse got=%b exp=1", bus.key_update); end
    tick(1);
    checks++; if (bus.key_update !== 1'b0) begin failures++; $display("FAIL press_pulse_end got=%b exp=0", bus.key_update); end
    checks++; if (upd - base !== 1) begin failures++; $display("FAIL press_pulses got=%0d exp=1", upd - base); end
  endtask

  task automatic test_bounce;
    start(16'h0000);
    base = upd;
    for (int i = 0; i < 10; i++) begin
      pressed[9] = ~pressed[9];
      tick(20);
      checks++; if (bus.key !== 16'h0000) begin failures++; $display("FAIL bounce_hold%0d got=%h exp=0000", i, bus.key); end
    end
    pressed = 16'h0200;
    tick(39);
    checks++; if (bus.key !== 16'h0000) begin failures++; $display("FAIL bounce_early got=%h exp=0000", bus.key); end
    tick(1);
    checks++; if (bus.key !== 16'h0200) begin failures++; $display("FAIL bounce_key got=%h exp=0200", bus.key); end
    tick(1);
    checks++; if (upd - base !== 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", upd - base); end
  endtask

  task automatic test_release_multi;
    start(16'h8001);
    base = upd;
    tick(48);
    checks++; if (bus.key !== 16'h8001) begin failures++; $display("FAIL multi_key got=%h exp=8001", bus.key); end
    pressed = 16'h0000;
    tick(47);
    checks++; if (bus.key !== 16'h8001) begin failures++; $display("FAIL release_early got=%h exp=8001", bus.key); end
    tick(1);
    checks++; if (bus.key !== 16'h0000) begin failures++; $display("FAIL release_key got=%h exp=0000", bus.key); end
    tick(1);
    checks++; if (upd - base !== 2) begin failures++; $display("FAIL multi_pulses got=%0d exp=2", upd - base); end
  endtask

  task automatic test_ghost;
    logic [15:0] exp_key;
    int exp_pulses;
`ifdef MATRIX_KEY_GHOST_REJECT_EN
    exp_key = 16'h8000;
    exp_pulses = 0;
`else
    exp_key = 16'h0013;
    exp_pulses = 1;
`endif
    start(16'h8000);
    tick(48);
    checks++; if (bus.key !== 16'h8000) begin failures++; $display("FAIL ghost_prior got=%h exp=8000", bus.key); end
    pressed = 16'h0013;
    tick(2);
    base = upd;
    tick(46);
    checks++; if (bus.key !== exp_key) begin failures++; $display("FAIL ghost_key got=%h exp=%h", bus.key, exp_key); end
    tick(20);
    checks++; if (bus.key !== exp_key) begin failures++; $display("FAIL ghost_key_late got=%h exp=%h", bus.key, exp_key); end
    checks++; if (upd - base !== exp_pulses) begin failures++; $display("FAIL ghost_pulses got=%0d exp=%0d", upd - base, exp_pulses); end
  endtask

  initial begin
    rst = 1'b0;
    pressed = '0;
    #1;
    test_reset;
    test_single_press;
    test_bounce;
    test_release_multi;
    test_ghost;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
